// File: rtl/latch_q_sync_filter_if.sv
// Bundle between the latch-output filter and its synchronous consumer.
// The controller side drives the raw latch level and the counter clear.
// The filter side returns the clean level, strobes, busy flag and counter.
interface latch_q_sync_filter_if #(
  parameter int CNT_W = 8
);
  logic             q_in;
  logic             clr_in;
  logic             level_out;
  logic             rise_out;
  logic             fall_out;
  logic             busy_out;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_sat_out;

  modport master (
    output q_in, clr_in,
    input  level_out, rise_out, fall_out, busy_out, cnt_out, cnt_sat_out
  );

  modport slave (
    input  q_in, clr_in,
    output level_out, rise_out, fall_out, busy_out, cnt_out, cnt_sat_out
  );
endinterface

// File: rtl/latch_q_sync_filter.sv
// Synchronizes the asynchronous latch output and rejects glitches shorter than STABLE_CYCLES.
// Latency: SYNC_STAGES+STABLE_CYCLES edges from a q_in change to level_out and the strobe.
// No backpressure: strobes are single-cycle pulses. The transition counter exists only with LATCH_SYNC_CNT_EN.
module latch_q_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  latch_q_sync_filter_if.slave  bus
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   accept;

  // Plain flop chain; the first stage is the only one that sees the asynchronous input.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.q_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Qualify a differing synchronized value for STABLE_CYCLES consecutive samples before accepting it.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s != level_q) begin
          if (STABLE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = CHECK;
            stab_d  = STAB_W'(1);
          end
        end
      end
      CHECK: begin
        if (s == level_q) begin
          // Input went back before qualifying: treat it as a glitch.
          state_d = IDLE;
          stab_d  = '0;
        end else if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
          accept = 1'b1;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase
    if (accept) begin
      level_d = s;
      stab_d  = '0;
      state_d = IDLE;
    end
    rise_d = accept & s;
    fall_d = accept & ~s;
  end

  // FSM state, filtered level and strobes; reset drops any pending qualification.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      stab_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.rise_out  = rise_q;
  assign bus.fall_out  = fall_q;
  assign bus.busy_out  = (state_q == CHECK);

`ifdef LATCH_SYNC_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Saturating count of accepted transitions; a clear on the same edge wins over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_in) begin
      cnt_d = '0;
    end else if (accept && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = &cnt_d;
  end

  // Counter and its registered saturation flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign bus.cnt_out     = cnt_q;
  assign bus.cnt_sat_out = sat_q;
`else
  assign bus.cnt_out     = '0;
  assign bus.cnt_sat_out = 1'b0;
`endif

endmodule

// File: tb/tb_latch_q_sync_filter.sv
// Self-checking bench for latch_q_sync_filter with SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=3.
// Directed scenarios are checked against edge-numbered expectations; random traffic is checked
// against a run-length reference model. Counter expectations follow LATCH_SYNC_CNT_EN.
module tb_latch_q_sync_filter;

  localparam int SYNC    = 2;
  localparam int STAB    = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LATCH_SYNC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  latch_q_sync_filter_if #(.CNT_W(CNT_W)) bus ();

  latch_q_sync_filter #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference model: the synchronized value seen at an edge is q_in as sampled SYNC edges
  // earlier; a new level is accepted when STAB consecutive seen samples differ from it.
  bit   qhist[$];
  logic m_level, m_rise, m_fall, m_busy;
  int   m_run, m_cnt;

  function automatic void model_reset();
    qhist.delete();
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    m_run = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input logic q, input logic clr);
    bit s;
    bit acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = (qhist.size() >= SYNC) ? qhist[qhist.size() - SYNC] : 1'b0;
    qhist.push_back(q);
    if (qhist.size() > SYNC) void'(qhist.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = (s != m_level) ? m_run + 1 : 0;
    acc    = (m_run >= STAB);
    if (acc) begin
      m_level = s;
      m_rise  = s;
      m_fall  = !s;
      m_run   = 0;
    end
    if (clr) m_cnt = 0;
    else if (acc && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    m_busy = (m_run > 0);
  endfunction

  function automatic logic [7:0] mk(input logic l, input logic r, input logic f,
                                    input logic b, input int c, input logic sat);
    return {l, r, f, b, 3'(c), sat};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.level_out, bus.rise_out, bus.fall_out, bus.busy_out, bus.cnt_out, bus.cnt_sat_out};
  endfunction

  function automatic logic [7:0] model_vec();
    return mk(m_level, m_rise, m_fall, m_busy, CNT_EN ? m_cnt : 0, CNT_EN && (m_cnt == CNT_MAX));
  endfunction

  // Drive inputs, take one rising edge, advance the model, then settle 1 time unit past the edge.
  task automatic step(input logic q, input logic clr);
    bus.q_in   = q;
    bus.clr_in = clr;
    @(posedge clk);
    model_edge(q, clr);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    bus.q_in = 1'b1;
    bus.clr_in = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 8'h00) $display("FAIL reset_state got=%h exp=%h", dut_vec(), 8'h00);
    else n_pass++;
    repeat (3) step(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b0);
      exp = mk(e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5), (CNT_EN && e >= 6) ? 1 : 0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp) $display("FAIL reset_q_high edge%0d got=%h exp=%h", e, dut_vec(), exp);
      else n_pass++;
    end
  endtask

  task automatic test_fall();
    logic [7:0] exp;
    int c0;
    repeat (4) step(1'b1, 1'b0);
    c0 = CNT_EN ? m_cnt : 0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      exp = mk(e < 6, 1'b0, e == 6, (e >= 3 && e <= 5), (e >= 6) ? c0 + (CNT_EN ? 1 : 0) : c0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp) $display("FAIL fall edge%0d got=%h exp=%h", e, dut_vec(), exp);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    int c0, busy_n;
    repeat (4) step(1'b0, 1'b0);
    c0 = CNT_EN ? m_cnt : 0;
    busy_n = 0;
    for (int e = 1; e <= 9; e++) begin
      step(e <= 3, 1'b0);
      if (bus.busy_out === 1'b1) busy_n++;
      exp = mk(1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5), c0, 1'b0);
      n_checks++;
      if (dut_vec() !== exp) $display("FAIL glitch edge%0d got=%h exp=%h", e, dut_vec(), exp);
      else n_pass++;
    end
    n_checks++;
    if (busy_n !== 3) $display("FAIL glitch_busy_cycles got=%0d exp=3", busy_n);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [7:0] exp;
    logic q;
    q = 1'b0;
    step(q, 1'b1);
    for (int i = 0; i < 10; i++) begin
      q = ~q;
      repeat (7) step(q, 1'b0);
    end
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, CNT_EN ? 7 : 0, CNT_EN);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL saturate got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
    step(q, 1'b1);
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL sat_clear got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    logic [7:0] exp;
    repeat (7) step(1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) step(1'b0, 1'b0);
    exp = mk(1'b1, 1'b0, 1'b0, 1'b1, CNT_EN ? 1 : 0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL clrpri_pre got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
    step(1'b0, 1'b1);
    exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL clrpri_accept got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
    step(1'b0, 1'b0);
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL clrpri_after got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
  endtask

  task automatic test_reset_midcheck();
    logic [7:0] exp;
    repeat (3) step(1'b1, 1'b0);
    exp = mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp) $display("FAIL midcheck_busy got=%h exp=%h", dut_vec(), exp);
    else n_pass++;
    bus.q_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 8'h00) $display("FAIL midcheck_async got=%h exp=%h", dut_vec(), 8'h00);
    else n_pass++;
    repeat (2) step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== 8'h00) $display("FAIL midcheck_release edge%0d got=%h exp=%h", e, dut_vec(), 8'h00);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic q;
    logic clr;
    int hold;
    int cyc;
    q = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      q = ($urandom_range(0, 1) == 1) ? ~q : q;
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        clr = ($urandom_range(0, 15) == 0);
        step(q, clr);
        cyc++;
        n_checks++;
        if (dut_vec() !== model_vec())
          $display("FAIL random cyc%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.q_in   = 1'b0;
    bus.clr_in = 1'b0;
    test_reset();
    test_fall();
    test_glitch();
    test_saturation();
    test_clear_priority();
    test_reset_midcheck();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
